dmem_port_arbiter: RTL

//  Shares the single data-memory port between the pipeline MEM stage (core) and a debug/loader

---
 rtl/dmem_port_arbiter_pkg.sv | 45 ++++
 rtl/dmem_port_arbiter_starve_cnt.sv | 44 ++++
 rtl/dmem_port_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg
//   Shared types for the data-memory port arbiter: the request bundle that is muxed onto the
//   datamemory port, the registered-owner FSM states, and the combinational grant kinds.
package dmem_port_arbiter_pkg;

    // Request bundle widths are fixed here. The arbiter's DM_ADDRESS/DATA_W defaults follow these
    // values and must stay equal to them.
    localparam int unsigned DMEM_ADDR_W = 9;
    localparam int unsigned DMEM_DATA_W = 32;

    typedef struct packed {
        logic                   rd;
        logic                   wr;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic [2:0]             func3;
    } dmem_req_t;

    // Owner of the memory port in the previous cycle.
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_CORE,
        ARB_DBG_RD,
        ARB_DBG_WR
    } arb_state_e;

    // Owner of the memory port in the current cycle (combinational).
    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CORE,
        GNT_DBG
    } arb_grant_e;

    // The FSM's next state is simply the kind of grant made this cycle.
    function automatic arb_state_e grant_to_state(input arb_grant_e grant, input logic dbg_we);
        arb_state_e st;
        unique case (grant)
            GNT_CORE: st = ARB_CORE;
            GNT_DBG:  st = dbg_we ? ARB_DBG_WR : ARB_DBG_RD;
            default:  st = ARB_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_starve_cnt.sv
// arb_starve_cnt
//   Counts consecutive cycles in which a valid dbg request was refused because the core won the
//   port. When the count reaches MAX_WAIT, force_dbg asks the arbiter to grant dbg once.
// Ports
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   inc        in   dbg was valid but the core was granted this cycle
//   clr        in   dbg was granted, or dbg is not requesting
//   force_dbg  out  wait count has reached MAX_WAIT
module arb_starve_cnt #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic force_dbg
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] wait_q;
    logic [CW-1:0] wait_d;

    assign force_dbg = (wait_q == CW'(MAX_WAIT));

    always_comb begin
        wait_d = wait_q;
        if (clr) begin
            wait_d = '0;
        end else if (inc && !force_dbg) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single data-memory port between the MEM stage (core) and a debug/loader master
//   (dbg). The core has priority unless it is halted or dbg has been refused MAX_WAIT cycles in
//   a row, in which case dbg wins one cycle and the core is stalled. Dbg reads return their data
//   through a registered response one cycle after the grant.
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   core_rd/wr/addr/wdata/func3     MEM-stage request
//   core_halt                       core halted: dbg has absolute priority
//   core_stall                      core request refused this cycle
//   core_rdata                      mem_rdata when the core is granted, else 0
//   dbg_valid/we/addr/wdata/func3   dbg request
//   dbg_ready                       dbg request accepted this cycle
//   dbg_rvalid, dbg_rdata           registered dbg read response
//   mem_rd/wr/addr/wdata/func3      to datamemory
//   mem_rdata                       from datamemory (combinational read)
//   stall_count                     saturating count of core_stall cycles
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned DM_ADDRESS = DMEM_ADDR_W,
    parameter int unsigned DATA_W     = DMEM_DATA_W,
    parameter int unsigned MAX_WAIT   = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_rd,
    input  logic                  core_wr,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_func3,
    input  logic                  core_halt,
    output logic                  core_stall,
    output logic [DATA_W-1:0]     core_rdata,
    input  logic                  dbg_valid,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    input  logic [2:0]            dbg_func3,
    output logic                  dbg_ready,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_func3,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [CNT_W-1:0]      stall_count
);

    logic       core_req;
    logic       force_dbg;
    arb_grant_e grant;
    arb_state_e state_q;
    arb_state_e state_d;
    dmem_req_t  req_core;
    dmem_req_t  req_dbg;
    dmem_req_t  req_mem;

    logic [DATA_W-1:0] dbg_rdata_q;
    logic [CNT_W-1:0]  stall_count_q;

    assign core_req = core_rd | core_wr;

    // Grant decision. A halted core, an idle core, or a starved dbg master all hand the port to
    // dbg; otherwise any core request wins.
    always_comb begin
        grant = GNT_NONE;
        if (dbg_valid && (core_halt || !core_req || force_dbg)) begin
            grant = GNT_DBG;
        end else if (core_req) begin
            grant = GNT_CORE;
        end
    end

    assign core_stall = core_req && (grant != GNT_CORE);
    assign dbg_ready  = (grant == GNT_DBG);
    assign core_rdata = (grant == GNT_CORE) ? mem_rdata : '0;

    arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk       (clk),
        .reset     (reset),
        .inc       (dbg_valid && (grant == GNT_CORE)),
        .clr       (!dbg_valid || (grant == GNT_DBG)),
        .force_dbg (force_dbg)
    );

    // Memory port mux. An idle port drives all-zero fields so datamemory sees no stale address.
    always_comb begin
        req_core = '{
            rd:    core_rd,
            wr:    core_wr,
            addr:  core_addr,
            wdata: core_wdata,
            func3: core_func3
        };
        req_dbg = '{
            rd:    !dbg_we,
            wr:    dbg_we,
            addr:  dbg_addr,
            wdata: dbg_wdata,
            func3: dbg_func3
        };
        req_mem = '0;
        unique case (grant)
            GNT_CORE: req_mem = req_core;
            GNT_DBG:  req_mem = req_dbg;
            default:  req_mem = '0;
        endcase
    end

    assign mem_rd    = req_mem.rd;
    assign mem_wr    = req_mem.wr;
    assign mem_addr  = req_mem.addr;
    assign mem_wdata = req_mem.wdata;
    assign mem_func3 = req_mem.func3;

    // Registered owner of the previous cycle.
    always_comb begin
        state_d = grant_to_state(grant, dbg_we);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read data is captured on the edge that enters ARB_DBG_RD and held until the next dbg read.
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_rdata_q <= '0;
        end else if (state_d == ARB_DBG_RD) begin
            dbg_rdata_q <= mem_rdata;
        end
    end

    assign dbg_rvalid = (state_q == ARB_DBG_RD);
    assign dbg_rdata  = dbg_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
        end else if (core_stall && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + 1'b1;
        end
    end

    assign stall_count = stall_count_q;

    core_rd_wr_exclusive : assert property (@(posedge clk) disable iff (reset)
        !(core_rd && core_wr));

    mem_rd_wr_exclusive : assert property (@(posedge clk) disable iff (reset)
        !(mem_rd && mem_wr));

endmodule
